// File: rtl/pattern_timing_ctrl.sv
// Raster timing sequencer for the pattern generator: multi-pixel-per-clock
// HS/VS/DE with clean frame-boundary start/stop, coordinates and frame count.
module pattern_timing_ctrl #(
  parameter int C_PORT_NUM = 4,
  parameter int C_H_ACTIVE = 1920,
  parameter int C_H_FP     = 88,
  parameter int C_H_SYNC   = 44,
  parameter int C_H_BP     = 148,
  parameter int C_V_ACTIVE = 1080,
  parameter int C_V_FP     = 4,
  parameter int C_V_SYNC   = 5,
  parameter int C_V_BP     = 36,
  parameter int C_SYNC_POL = 1
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  input  logic        EN_I,
  output logic        VS_O,
  output logic        HS_O,
  output logic        DE_O,
  output logic        FRAME_START_O,
  output logic [15:0] X_O,
  output logic [15:0] Y_O,
  output logic [15:0] FRAME_CNT_O,
  output logic        BUSY_O
);

  localparam logic [15:0] PN    = 16'(C_PORT_NUM);
  localparam logic [15:0] HT    = 16'((C_H_SYNC + C_H_BP + C_H_ACTIVE + C_H_FP) / C_PORT_NUM);
  localparam logic [15:0] VT    = 16'(C_V_SYNC + C_V_BP + C_V_ACTIVE + C_V_FP);
  localparam logic [15:0] HS_W  = 16'(C_H_SYNC / C_PORT_NUM);
  localparam logic [15:0] VS_W  = 16'(C_V_SYNC);
  localparam logic [15:0] HA0   = 16'((C_H_SYNC + C_H_BP) / C_PORT_NUM);
  localparam logic [15:0] HA1   = 16'((C_H_SYNC + C_H_BP + C_H_ACTIVE) / C_PORT_NUM);
  localparam logic [15:0] VA0   = 16'(C_V_SYNC + C_V_BP);
  localparam logic [15:0] VA1   = 16'(C_V_SYNC + C_V_BP + C_V_ACTIVE);
  localparam logic [15:0] HT_M1 = HT - 16'd1;
  localparam logic [15:0] VT_M1 = VT - 16'd1;
  localparam logic        POL   = (C_SYNC_POL != 0);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t      state_q, state_d;
  logic [15:0] hc_q, hc_d;
  logic [15:0] vc_q, vc_d;
  logic        vs_q, vs_d;
  logic        hs_q, hs_d;
  logic        de_q, de_d;
  logic        fs_q, fs_d;
  logic [15:0] x_q, x_d;
  logic [15:0] y_q, y_d;
  logic [15:0] fcnt_q;
  logic        last_beat;
  logic        active;

  assign last_beat = (hc_q == HT_M1) && (vc_q == VT_M1);
  assign active    = (state_q != IDLE);

  always_comb begin
    state_d = state_q;
    hc_d    = hc_q;
    vc_d    = vc_q;
    case (state_q)
      IDLE: begin
        if (EN_I) state_d = RUN;
      end
      RUN: begin
        if (!EN_I) state_d = DRAIN;
      end
      DRAIN: begin
        if (EN_I)           state_d = RUN;
        else if (last_beat) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Counters free-run in RUN and DRAIN; leaving DRAIN happens only on the
    // last beat, so the wrap below also returns them to 0 for IDLE.
    if (active) begin
      if (hc_q == HT_M1) begin
        hc_d = 16'd0;
        vc_d = (vc_q == VT_M1) ? 16'd0 : vc_q + 16'd1;
      end else begin
        hc_d = hc_q + 16'd1;
      end
    end
  end

  always_comb begin
    de_d = active && (hc_q >= HA0) && (hc_q < HA1) && (vc_q >= VA0) && (vc_q < VA1);
    hs_d = (active && (hc_q < HS_W)) ? POL : ~POL;
    vs_d = (active && (vc_q < VS_W)) ? POL : ~POL;
    fs_d = active && (hc_q == 16'd0) && (vc_q == 16'd0);
    x_d  = de_d ? (hc_q - HA0) * PN : 16'd0;
    y_d  = de_d ? (vc_q - VA0) : 16'd0;
  end

  always_ff @(posedge CLK_I or posedge RST_I) begin
    if (RST_I) begin
      state_q <= IDLE;
      hc_q    <= 16'd0;
      vc_q    <= 16'd0;
      vs_q    <= ~POL;
      hs_q    <= ~POL;
      de_q    <= 1'b0;
      fs_q    <= 1'b0;
      x_q     <= 16'd0;
      y_q     <= 16'd0;
      fcnt_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      hc_q    <= hc_d;
      vc_q    <= vc_d;
      vs_q    <= vs_d;
      hs_q    <= hs_d;
      de_q    <= de_d;
      fs_q    <= fs_d;
      x_q     <= x_d;
      y_q     <= y_d;
      if (fs_d) fcnt_q <= fcnt_q + 16'd1;
    end
  end

  assign VS_O          = vs_q;
  assign HS_O          = hs_q;
  assign DE_O          = de_q;
  assign FRAME_START_O = fs_q;
  assign X_O           = x_q;
  assign Y_O           = y_q;
  assign FRAME_CNT_O   = fcnt_q;
  assign BUSY_O        = (state_q != IDLE);

endmodule

// File: tb/tb_pattern_timing_ctrl.sv
// Directed bench for pattern_timing_ctrl on a small 8x8-beat raster.
module tb_pattern_timing_ctrl;

  logic        clk;
  logic        rst;
  logic        en;
  logic        vs, hs, de, fs, busy;
  logic [15:0] x, y, fcnt;

  int checks;
  int failures;

  pattern_timing_ctrl #(
    .C_PORT_NUM(4),
    .C_H_ACTIVE(16), .C_H_FP(4), .C_H_SYNC(4), .C_H_BP(8),
    .C_V_ACTIVE(4),  .C_V_FP(1), .C_V_SYNC(1), .C_V_BP(2),
    .C_SYNC_POL(1)
  ) dut (
    .CLK_I(clk), .RST_I(rst), .EN_I(en),
    .VS_O(vs), .HS_O(hs), .DE_O(de), .FRAME_START_O(fs),
    .X_O(x), .Y_O(y), .FRAME_CNT_O(fcnt), .BUSY_O(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    en  = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    en  = 1'b0;
    tick();
    tick();
    checks++;
    if (hs !== 1'b0 || vs !== 1'b0 || de !== 1'b0 || fs !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: hs=%b vs=%b de=%b fs=%b busy=%b, required all 0", hs, vs, de, fs, busy);
    end
    checks++;
    if (fcnt !== 16'd0 || x !== 16'd0 || y !== 16'd0) begin
      failures++;
      $display("FAIL reset_data: fcnt=%0d x=%0d y=%0d, required 0/0/0", fcnt, x, y);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0 || hs !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset: busy=%b hs=%b, required 0/0", busy, hs);
    end
  endtask

  task automatic test_single_frame();
    int busy_n, fs_n, vs_n, hs_n;
    do_reset();
    en = 1'b1;
    tick();
    en = 1'b0;
    checks++;
    if (busy !== 1'b1 || hs !== 1'b0 || fs !== 1'b0) begin
      failures++;
      $display("FAIL start_latency: busy=%b hs=%b fs=%b, required 1/0/0", busy, hs, fs);
    end
    busy_n = 1; fs_n = 0; vs_n = 0; hs_n = 0;
    for (int s = 1; s <= 66; s++) begin
      tick();
      busy_n += int'(busy);
      fs_n   += int'(fs);
      vs_n   += int'(vs);
      hs_n   += int'(hs);
      if (s == 1) begin
        checks++;
        if (fs !== 1'b1 || vs !== 1'b1 || hs !== 1'b1 || fcnt !== 16'd1) begin
          failures++;
          $display("FAIL first_beat: fs=%b vs=%b hs=%b fcnt=%0d, required 1/1/1/1", fs, vs, hs, fcnt);
        end
      end
    end
    checks++;
    if (busy_n != 64) begin
      failures++;
      $display("FAIL single_busy_clocks: got %0d, required 64", busy_n);
    end
    checks++;
    if (fs_n != 1 || fcnt !== 16'd1) begin
      failures++;
      $display("FAIL single_frame_start: pulses=%0d fcnt=%0d, required 1/1", fs_n, fcnt);
    end
    checks++;
    if (vs_n != 8 || hs_n != 8) begin
      failures++;
      $display("FAIL single_sync_beats: vs=%0d hs=%0d, required 8/8", vs_n, hs_n);
    end
    checks++;
    if (busy !== 1'b0 || hs !== 1'b0 || vs !== 1'b0 || de !== 1'b0) begin
      failures++;
      $display("FAIL single_end_idle: busy=%b hs=%b vs=%b de=%b, required 0", busy, hs, vs, de);
    end
  endtask

  task automatic test_de_geometry();
    int de_n, bad;
    int hc, vc;
    logic        de_e;
    logic [15:0] x_e, y_e;
    do_reset();
    en = 1'b1;
    tick();
    en = 1'b0;
    de_n = 0; bad = 0;
    for (int b = 0; b < 64; b++) begin
      tick();
      hc   = b % 8;
      vc   = b / 8;
      de_e = (hc >= 3 && hc <= 6 && vc >= 3 && vc <= 6);
      x_e  = de_e ? 16'((hc - 3) * 4) : 16'd0;
      y_e  = de_e ? 16'(vc - 3) : 16'd0;
      de_n += int'(de);
      checks++;
      if (de !== de_e || x !== x_e || y !== y_e) begin
        failures++;
        bad++;
        if (bad < 6)
          $display("FAIL de_beat%0d: de=%b x=%0d y=%0d, required de=%b x=%0d y=%0d",
                   b, de, x, y, de_e, x_e, y_e);
      end
    end
    checks++;
    if (de_n != 16) begin
      failures++;
      $display("FAIL de_count: got %0d, required 16", de_n);
    end
    repeat (3) tick();
  endtask

  task automatic test_continuous();
    int busy_n, de_n, fs_n;
    int fs_pos[3];
    do_reset();
    en = 1'b1;
    tick();
    busy_n = 1; de_n = 0; fs_n = 0;
    for (int s = 1; s <= 200; s++) begin
      if (s == 140) en = 1'b0;
      tick();
      busy_n += int'(busy);
      de_n   += int'(de);
      if (fs === 1'b1) begin
        if (fs_n < 3) fs_pos[fs_n] = s;
        fs_n++;
      end
    end
    checks++;
    if (fs_n != 3 || fcnt !== 16'd3) begin
      failures++;
      $display("FAIL cont_frames: pulses=%0d fcnt=%0d, required 3/3", fs_n, fcnt);
    end
    checks++;
    if (fs_n >= 3 && (fs_pos[0] != 1 || fs_pos[1] != 65 || fs_pos[2] != 129)) begin
      failures++;
      $display("FAIL cont_spacing: starts at %0d,%0d,%0d, required 1,65,129",
               fs_pos[0], fs_pos[1], fs_pos[2]);
    end
    checks++;
    if (busy_n != 192 || de_n != 48) begin
      failures++;
      $display("FAIL cont_busy_de: busy=%0d de=%0d, required 192/48", busy_n, de_n);
    end
  endtask

  task automatic test_drain_reenable();
    int busy_n, fs_n, fs2;
    logic busy_drop;
    do_reset();
    en = 1'b1;
    tick();
    busy_n = 1; fs_n = 0; fs2 = -1; busy_drop = 1'b0;
    for (int s = 1; s <= 140; s++) begin
      if (s == 20) en = 1'b0;
      if (s == 40) en = 1'b1;
      if (s == 84) en = 1'b0;
      tick();
      busy_n += int'(busy);
      if (s < 128 && busy !== 1'b1) busy_drop = 1'b1;
      if (fs === 1'b1) begin
        fs_n++;
        if (fs_n == 2) fs2 = s;
      end
    end
    checks++;
    if (busy_drop) begin
      failures++;
      $display("FAIL drain_no_gap: busy=0 during frames, required 1");
    end
    checks++;
    if (fs_n != 2 || fs2 != 65 || fcnt !== 16'd2) begin
      failures++;
      $display("FAIL drain_frames: pulses=%0d second_at=%0d fcnt=%0d, required 2/65/2", fs_n, fs2, fcnt);
    end
    checks++;
    if (busy_n != 128) begin
      failures++;
      $display("FAIL drain_busy_clocks: got %0d, required 128", busy_n);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    en = 1'b1;
    tick();
    repeat (28) tick();
    checks++;
    if (de !== 1'b1 || x !== 16'd0 || y !== 16'd0) begin
      failures++;
      $display("FAIL pre_reset_de: de=%b x=%0d y=%0d, required 1/0/0", de, x, y);
    end
    tick();
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (de !== 1'b0 || hs !== 1'b0 || vs !== 1'b0 || busy !== 1'b0 || fs !== 1'b0 ||
        fcnt !== 16'd0 || x !== 16'd0 || y !== 16'd0) begin
      failures++;
      $display("FAIL async_reset: de=%b hs=%b vs=%b busy=%b fs=%b fcnt=%0d x=%0d y=%0d, required reset values",
               de, hs, vs, busy, fs, fcnt, x, y);
    end
    #1;
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b1 || fcnt !== 16'd0 || fs !== 1'b0) begin
      failures++;
      $display("FAIL restart_busy: busy=%b fcnt=%0d fs=%b, required 1/0/0", busy, fcnt, fs);
    end
    tick();
    checks++;
    if (fs !== 1'b1 || fcnt !== 16'd1 || vs !== 1'b1) begin
      failures++;
      $display("FAIL restart_frame: fs=%b fcnt=%0d vs=%b, required 1/1/1", fs, fcnt, vs);
    end
    en = 1'b0;
    repeat (70) tick();
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    en       = 1'b0;
    test_reset();
    test_single_frame();
    test_de_geometry();
    test_continuous();
    test_drain_reenable();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pattern_timing_ctrl.md
# pattern_timing_ctrl

Video timing sequencer that drives the pattern generator's VS/HS/DE inputs. It produces a programmable raster at C_PORT_NUM pixels per clock and starts and stops it cleanly on frame boundaries. It also reports the active-pixel coordinates and a frame count to downstream logic. It sits directly upstream of the pattern block in the same clock domain.

## Interface
- C_PORT_NUM, 4, pixels per clock; every horizontal parameter below must be divisible by it.
- C_H_ACTIVE, 1920, active pixels per line.
- C_H_FP, 88, horizontal front porch (pixels).
- C_H_SYNC, 44, horizontal sync width (pixels).
- C_H_BP, 148, horizontal back porch (pixels).
- C_V_ACTIVE, 1080, active lines per frame.
- C_V_FP, 4, vertical front porch (lines).
- C_V_SYNC, 5, vertical sync width (lines).
- C_V_BP, 36, vertical back porch (lines).
- C_SYNC_POL, 1, 1 = HS/VS active-high, 0 = active-low.
- CLK_I  in  1  pixel-beat clock.
- RST_I  in  1  reset, asynchronous, active-high.
- EN_I  in  1  run request, level-sensitive.
- VS_O  out  1  vertical sync, to pattern VS_I.
- HS_O  out  1  horizontal sync, to pattern HS_I.
- DE_O  out  1  data enable, to pattern DE_I.
- FRAME_START_O  out  1  one-clock pulse coincident with the first beat of each frame.
- X_O  out  16  active x of the first pixel in the current beat; steps by C_PORT_NUM.
- Y_O  out  16  active line index.
- FRAME_CNT_O  out  16  frames started since reset; wraps at 65535 -> 0.
- BUSY_O  out  1  high whenever state is not IDLE.

## Operation
- Derived constants (clocks and lines):
  - HT = (C_H_SYNC+C_H_BP+C_H_ACTIVE+C_H_FP)/C_PORT_NUM
  - VT = C_V_SYNC+C_V_BP+C_V_ACTIVE+C_V_FP
  - HA0 = (C_H_SYNC+C_H_BP)/C_PORT_NUM
  - HA1 = HA0 + C_H_ACTIVE/C_PORT_NUM
  - VA0 = C_V_SYNC+C_V_BP
  - VA1 = VA0 + C_V_ACTIVE
- Line order is sync, back porch, active, front porch; frame order uses the same sequence in lines.
- Counters:
  - hc counts 0..HT-1.
  - vc counts 0..VT-1 and increments when hc wraps.
  - In IDLE both are held at 0.
- Combinational decode, registered onto the outputs:
  - HS active when hc < C_H_SYNC/C_PORT_NUM.
  - VS active when vc < C_V_SYNC, aligned to hc=0.
  - DE when HA0 <= hc < HA1 and VA0 <= vc < VA1.
  - X = (hc-HA0)*C_PORT_NUM and Y = vc-VA0 while DE; otherwise both hold 0.
- State machine:
  - IDLE -> RUN when EN_I=1.
  - RUN -> DRAIN when EN_I=0.
  - DRAIN -> RUN when EN_I=1; there is no interruption and the counters continue.
  - DRAIN -> IDLE on the last beat of a frame (hc=HT-1, vc=VT-1).
  - In RUN, the last beat of a frame wraps hc and vc to 0 and the next frame starts with no gap.
- A frame is never truncated by EN_I. Only RST_I stops it mid-frame.
- FRAME_CNT_O increments by 1 in the same cycle that FRAME_START_O is asserted.
- While in IDLE:
  - HS_O and VS_O are at the inactive level (!C_SYNC_POL).
  - DE_O, FRAME_START_O, X_O and Y_O are 0.

## Timing
- Reset values:
  - VS_O = HS_O = !C_SYNC_POL.
  - DE_O = FRAME_START_O = BUSY_O = 0.
  - X_O = Y_O = FRAME_CNT_O = 0.
  - State is IDLE; hc = vc = 0.
- Reset asserted mid-frame forces all of the above immediately, asynchronously to CLK_I.
- Latency:
  - EN_I sampled high at edge k gives BUSY_O=1 after edge k.
  - VS_O, HS_O and FRAME_START_O assert after edge k+1 (counter-to-output latency is 1 clock).
- All of VS_O, HS_O, DE_O, X_O, Y_O and FRAME_START_O are mutually aligned and registered.
- End of frame when stopping: after the last beat of the final frame, BUSY_O falls 1 clock before the outputs return to idle levels.
- EN_I pulses shorter than one frame still produce exactly one full frame.

## Test plan
Bench parameters for all scenarios: C_PORT_NUM=4, H = 4/8/16/4 (sync/bp/active/fp), V = 1/2/4/1 (sync/bp/active/fp). This gives HT=8, VT=8 and 64 clocks per frame.

- Reset: hold RST_I=1 → HS_O=VS_O=0 (C_SYNC_POL=1), DE_O=0, FRAME_CNT_O=0, BUSY_O=0.
- Single frame: raise EN_I for 1 clock → exactly 64 busy clocks and one FRAME_START_O pulse; FRAME_CNT_O=1; VS_O high for 8 beats; HS_O high for 1 beat in each of 8 lines.
- DE geometry: per frame, DE_O is high for 16 beats, 4 per line, on lines 3..6 at hc 3..6. X_O sequence is 0,4,8,12; Y_O is 0..3.
- Continuous run: EN_I held for 3 frames → FRAME_START_O pulses spaced exactly 64 clocks apart; FRAME_CNT_O=3; no idle beat between frames.
- Drain/re-enable: drop EN_I at beat 20 of a frame and reassert it at beat 40 → the frame continues uninterrupted and the next frame starts at beat 64. Dropping it again without reassertion → IDLE after beat 63.
- Async reset mid-frame: assert RST_I during DE → all outputs reach reset values before the next CLK_I edge. After release with EN_I=1, the first frame restarts with FRAME_CNT_O=1.
